rf_write_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order WB stage and the multi-cycle
//  MUL/DIV unit (MDU). WB has absolute priority; MDU results queue in a small FIFO and drain in

---
 rtl/rf_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB stage has absolute priority, MDU results queue in a
// small FIFO and drain in idle WB slots; tracks pending MDU destinations and raises a starvation stall.
module rf_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WB_VALID,
  input  logic [4:0]  WB_ADDR,
  input  logic [31:0] WB_DATA,
  input  logic        MDU_VALID,
  output logic        MDU_READY,
  input  logic [4:0]  MDU_ADDR,
  input  logic [31:0] MDU_DATA,
  input  logic        ISSUE_VALID,
  input  logic [4:0]  ISSUE_RD,
  input  logic [4:0]  QUERY_ADDR1,
  input  logic [4:0]  QUERY_ADDR2,
  output logic        BUSY1,
  output logic        BUSY2,
  output logic        STALL_REQ,
  output logic        RF_WRITE_ENABLE,
  output logic [4:0]  RF_WRITE_ADDR,
  output logic [31:0] RF_WRITE_DATA
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ST_W   = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_BLOCKED, S_STARVE} state_t;

  state_t             state_q, state_d;
  logic [ST_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        pending_q, pending_d;
  logic               rf_we_q, rf_we_d;
  logic [4:0]         rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]  rf_data_q, rf_data_d;

  logic [4:0]         mem_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  mem_data_q [FIFO_DEPTH];

  logic               wb_used, fifo_empty, fifo_full, push, pop;
  logic [4:0]         head_addr;
  logic [DATA_W-1:0]  head_data;

  always_comb begin
    wb_used    = WB_VALID && (WB_ADDR != 5'd0);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    // Results for x0 are acknowledged but never occupy a slot.
    push       = MDU_VALID && !fifo_full && (MDU_ADDR != 5'd0);
    pop        = !wb_used && !fifo_empty;
    head_addr  = mem_addr_q[rd_ptr_q];
    head_data  = mem_data_q[rd_ptr_q];
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (!push && pop)
      count_d = count_q - 1'b1;

    pending_d = pending_q;
    if (pop)
      pending_d[head_addr] = 1'b0;
    // Applied after the clear so a same-edge re-issue keeps the register busy.
    if (ISSUE_VALID && (ISSUE_RD != 5'd0))
      pending_d[ISSUE_RD] = 1'b1;

    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (wb_used) begin
      rf_we_d   = 1'b1;
      rf_addr_d = WB_ADDR;
      rf_data_d = WB_DATA;
    end else if (pop) begin
      rf_we_d   = 1'b1;
      rf_addr_d = head_addr;
      rf_data_d = head_data;
    end
  end

  // Outside IDLE the FIFO is never empty, so a missing pop means WB took the slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (push)
          state_d = S_DRAIN;
      end
      S_DRAIN, S_BLOCKED, S_STARVE: begin
        if (pop) begin
          cnt_d   = '0;
          state_d = (count_d == '0) ? S_IDLE : S_DRAIN;
        end else if (cnt_q >= ST_W'(STARVE_LIMIT - 1)) begin
          cnt_d   = ST_W'(STARVE_LIMIT);
          state_d = S_STARVE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_BLOCKED;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= MDU_ADDR;
      mem_data_q[wr_ptr_q] <= MDU_DATA;
    end
  end

  assign MDU_READY       = !fifo_full;
  assign BUSY1           = (QUERY_ADDR1 != 5'd0) && pending_q[QUERY_ADDR1];
  assign BUSY2           = (QUERY_ADDR2 != 5'd0) && pending_q[QUERY_ADDR2];
  assign STALL_REQ       = (state_q == S_STARVE);
  assign RF_WRITE_ENABLE = rf_we_q;
  assign RF_WRITE_ADDR   = rf_addr_q;
  assign RF_WRITE_DATA   = rf_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, multi-cycle corner sequences and
// random traffic checked against a queue-based reference model.
module tb_rf_write_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        wb_valid, mdu_valid, issue_valid;
  logic [4:0]  wb_addr, mdu_addr, issue_rd, query1, query2;
  logic [31:0] wb_data, mdu_data;
  logic        mdu_ready, busy1, busy2, stall_req, rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  always #5 CLK = ~CLK;

  rf_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RESET(RESET),
    .WB_VALID(wb_valid), .WB_ADDR(wb_addr), .WB_DATA(wb_data),
    .MDU_VALID(mdu_valid), .MDU_READY(mdu_ready), .MDU_ADDR(mdu_addr), .MDU_DATA(mdu_data),
    .ISSUE_VALID(issue_valid), .ISSUE_RD(issue_rd),
    .QUERY_ADDR1(query1), .QUERY_ADDR2(query2), .BUSY1(busy1), .BUSY2(busy2),
    .STALL_REQ(stall_req), .RF_WRITE_ENABLE(rf_we), .RF_WRITE_ADDR(rf_addr),
    .RF_WRITE_DATA(rf_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of pending results, a busy bit per register, a blocked-run length.
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  bit          pend[32];
  int          run;
  logic        e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic        e_stall;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    run = 0; e_we = 1'b0; e_addr = '0; e_data = '0; e_stall = 1'b0;
  endtask

  task automatic model_step();
    bit   used, had, rdy;
    ent_t e;
    used = wb_valid && (wb_addr != 0);
    had  = mq.size() > 0;
    rdy  = mq.size() < DEPTH;
    if (used) begin
      e_we = 1'b1; e_addr = wb_addr; e_data = wb_data;
    end else if (had) begin
      e = mq.pop_front();
      e_we = 1'b1; e_addr = e.a; e_data = e.d;
      pend[e.a] = 1'b0;
    end else begin
      e_we = 1'b0;
    end
    if (used && had) run++;
    else run = 0;
    e_stall = (run >= LIMIT);
    if (mdu_valid && rdy && mdu_addr != 0) mq.push_back('{a: mdu_addr, d: mdu_data});
    if (issue_valid && issue_rd != 0) pend[issue_rd] = 1'b1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".we"},    32'(rf_we),     32'(e_we));
    chk({tag, ".addr"},  32'(rf_addr),   32'(e_addr));
    chk({tag, ".data"},  rf_data,        e_data);
    chk({tag, ".stall"}, 32'(stall_req), 32'(e_stall));
    chk({tag, ".ready"}, 32'(mdu_ready), 32'(mq.size() < DEPTH));
    chk({tag, ".busy1"}, 32'(busy1),     32'(query1 != 0 && pend[query1]));
    chk({tag, ".busy2"}, 32'(busy2),     32'(query2 != 0 && pend[query2]));
  endtask

  task automatic step(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic iv, input logic [4:0] ird,
                      input logic [4:0] q1, input logic [4:0] q2);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
    issue_valid = iv; issue_rd = ird; query1 = q1; query2 = q2;
    model_step();
    @(posedge CLK); #1;
  endtask

  task automatic clear_inputs();
    wb_valid = 0; wb_addr = 0; wb_data = 0; mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
    issue_valid = 0; issue_rd = 0; query1 = 0; query2 = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
  endtask

  typedef struct packed {
    logic wv; logic [4:0] wa; logic [31:0] wd;
    logic mv; logic [4:0] ma; logic [31:0] md;
    logic iv; logic [4:0] ird; logic [4:0] q1; logic [4:0] q2;
    logic ewe; logic [4:0] ea; logic [31:0] ed;
    logic est; logic erdy; logic eb1; logic eb2;
  } vec_t;

  vec_t tbl [10];
  int   exp_order [8] = '{11, 12, 13, 14, 20, 21, 22, 23};

  initial begin
    tbl[0] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    1'b1, 5'd6, 5'd6, 5'd0,
               1'b0, 5'd0, 32'h0,     1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22,   1'b0, 5'd0, 5'd6, 5'd5,
               1'b1, 5'd5, 32'h11,    1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd6, 5'd5,
               1'b1, 5'd6, 32'h22,    1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd6, 5'd0,
               1'b0, 5'd6, 32'h22,    1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 5'd0, 32'h55, 1'b1, 5'd9, 32'hABCD, 1'b1, 5'd7, 5'd7, 5'd9,
               1'b0, 5'd6, 32'h22,    1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd9,
               1'b1, 5'd9, 32'hABCD,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'h99,   1'b0, 5'd0, 5'd7, 5'd0,
               1'b0, 5'd9, 32'hABCD,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd0,
               1'b0, 5'd9, 32'hABCD,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'h77,   1'b0, 5'd0, 5'd7, 5'd0,
               1'b0, 5'd9, 32'hABCD,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 5'd7, 5'd6,
               1'b1, 5'd7, 32'h77,    1'b0, 1'b1, 1'b1, 1'b0};

    clear_inputs();
    model_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_model("reset");
    RESET = 1'b0;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].mv, tbl[i].ma, tbl[i].md,
           tbl[i].iv, tbl[i].ird, tbl[i].q1, tbl[i].q2);
      chk($sformatf("vec%0d.we", i),    32'(rf_we),     32'(tbl[i].ewe));
      chk($sformatf("vec%0d.addr", i),  32'(rf_addr),   32'(tbl[i].ea));
      chk($sformatf("vec%0d.data", i),  rf_data,        tbl[i].ed);
      chk($sformatf("vec%0d.stall", i), 32'(stall_req), 32'(tbl[i].est));
      chk($sformatf("vec%0d.ready", i), 32'(mdu_ready), 32'(tbl[i].erdy));
      chk($sformatf("vec%0d.busy1", i), 32'(busy1),     32'(tbl[i].eb1));
      chk($sformatf("vec%0d.busy2", i), 32'(busy2),     32'(tbl[i].eb2));
    end

    // Fill under continuous WB, starvation stall, then drain in order
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'(1 + i), 32'h100 + i, 1'b1, 5'(10 + i), 32'hA0 + i, 1'b0, 5'd0, 5'd0, 5'd0);
      check_model("fill");
      if (i == 2) chk("fill.stall_early", 32'(stall_req), 32'd0);
    end
    chk("fill.ready_full", 32'(mdu_ready), 32'd0);
    chk("fill.stall_set", 32'(stall_req), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      check_model("drain");
      chk("drain.addr", 32'(rf_addr), 32'(10 + i));
      chk("drain.data", rf_data, 32'hA0 + i);
      if (i == 0) begin
        chk("drain.stall_clr", 32'(stall_req), 32'd0);
        chk("drain.ready_back", 32'(mdu_ready), 32'd1);
      end
    end

    // Push and pop on the same edge across pointer wrap
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'(1 + i), 32'h200 + i, 1'b1, 5'(11 + i), 32'hB0 + i, 1'b0, 5'd0, 5'd0, 5'd0);
      check_model("wrapfill");
    end
    begin
      int k = 0;
      for (int c = 0; c < 8; c++) begin
        bit rdy;
        bit offer;
        rdy   = mq.size() < DEPTH;
        offer = (k < 4);
        step(1'b0, 5'd0, 32'h0, offer, 5'(20 + k), 32'hC0 + k, 1'b0, 5'd0, 5'd0, 5'd0);
        if (offer && rdy) k++;
        check_model("wrap");
        chk("wrap.we", 32'(rf_we), 32'd1);
        chk("wrap.order", 32'(rf_addr), 32'(exp_order[c]));
      end
    end

    // Asynchronous reset in the middle of a drain
    do_reset();
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd24, 5'd24, 5'd25);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd25, 5'd24, 5'd25);
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'(1 + i), 32'h300 + i, 1'b1, 5'(24 + i), 32'hD0 + i, 1'b0, 5'd0, 5'd24, 5'd25);
    check_model("prereset");
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd24, 5'd25);
    #3;
    wb_valid = 0; mdu_valid = 0; issue_valid = 0;
    RESET = 1'b1;
    #1;
    chk("rst.ready", 32'(mdu_ready), 32'd1);
    chk("rst.we", 32'(rf_we), 32'd0);
    chk("rst.busy1", 32'(busy1), 32'd0);
    chk("rst.busy2", 32'(busy2), 32'd0);
    chk("rst.stall", 32'(stall_req), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    check_model("postrst");
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd24, 5'd25);
    check_model("postrst_idle");

    // Random traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      int          pct;
      logic        wv, mv, iv;
      logic [4:0]  wa, ma, ird, q1, q2;
      pct = ((c / 40) % 2 == 0) ? 90 : 30;
      wv  = ($urandom_range(0, 99) < pct);
      wa  = 5'($urandom_range(0, 31));
      if (pend[wa]) wa = 5'd0;
      mv  = ($urandom_range(0, 99) < 50);
      ma  = 5'($urandom_range(0, 31));
      iv  = ($urandom_range(0, 99) < 30);
      ird = 5'($urandom_range(0, 31));
      if (pend[ird]) iv = 1'b0;
      q1  = 5'($urandom_range(0, 31));
      q2  = 5'($urandom_range(0, 31));
      step(wv, wa, $urandom, mv, ma, $urandom, iv, ird, q1, q2);
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
